// File: rtl/rx_timer_ctrl.sv
// Receive bit timer: times P-cycle bit periods for a B-bit frame, strobing at each bit end.
// Optional half-bit ALIGN phase before the first bit when RX_TIMER_ALIGN_EN is defined.
module rx_timer_ctrl #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_IDX_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] clks_per_bit,
    input  logic [NUM_IDX_BITS-1:0] bits_per_frame,
    output logic                    busy,
    output logic                    sample_strobe,
    output logic [NUM_IDX_BITS-1:0] bit_index,
    output logic                    frame_done,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] CNT_TWO = NUM_CNT_BITS'(2);
    localparam logic [NUM_IDX_BITS-1:0] IDX_ONE = NUM_IDX_BITS'(1);

    state_t                  state, state_nxt;
    logic [NUM_CNT_BITS-1:0] cnt, cnt_nxt;
    logic [NUM_CNT_BITS-1:0] p_q, p_nxt;
    logic [NUM_IDX_BITS-1:0] b_q, b_nxt;
    logic [NUM_IDX_BITS-1:0] idx, idx_nxt;
    logic                    cfg_err_nxt;
    logic                    cfg_ok;

    assign cfg_ok        = (clks_per_bit >= CNT_TWO) && (bits_per_frame >= IDX_ONE);
    assign busy          = (state != IDLE);
    assign sample_strobe = (state == RUN) && (cnt == p_q);
    assign frame_done    = (state == DONE);
    assign bit_index     = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            p_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            p_q     <= p_nxt;
            b_q     <= b_nxt;
            idx     <= idx_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        p_nxt       = p_q;
        b_nxt       = b_q;
        idx_nxt     = idx;
        cfg_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (start) begin
                    if (cfg_ok) begin
                        p_nxt   = clks_per_bit;
                        b_nxt   = bits_per_frame;
                        cnt_nxt = CNT_ONE;
`ifdef RX_TIMER_ALIGN_EN
                        state_nxt = ALIGN;
`else
                        state_nxt = RUN;
`endif
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
`ifdef RX_TIMER_ALIGN_EN
            ALIGN: begin
                // Half a bit period so that strobes land mid-bit
                if (cnt == (p_q >> 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`endif
            RUN: begin
                if (sample_strobe) begin
                    cnt_nxt = CNT_ONE;
                    if (idx == b_q - IDX_ONE) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
        // Abort only redirects the next state; this cycle's outputs stand
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Bench for rx_timer_ctrl: frames are predicted as event lists (strobe/done/cfg_err with cycle numbers)
// from the timing rules; a negedge monitor pops and compares whenever the DUT emits an event.
module tb_rx_timer_ctrl;
    localparam int CW = 4;
    localparam int IW = 4;
`ifdef RX_TIMER_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        int kind;   // 0 strobe, 1 frame_done, 2 cfg_err
        int cyc;
        int idx;
    } evt_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] clks_per_bit = '0;
    logic [IW-1:0] bits_per_frame = '0;
    logic          busy, sample_strobe, frame_done, cfg_err;
    logic [IW-1:0] bit_index;

    rx_timer_ctrl #(.NUM_CNT_BITS(CW), .NUM_IDX_BITS(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .clks_per_bit(clks_per_bit), .bits_per_frame(bits_per_frame),
        .busy(busy), .sample_strobe(sample_strobe), .bit_index(bit_index),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    evt_t q[$];
    int   bs = 1;        // expected busy interval [bs, be]
    int   be = 0;
    bit   mon_en = 1'b0;
    int   cur_p = 4;
    int   cur_b = 3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_evt(input int kind, input int idx);
        evt_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event at cycle %0d: got kind %0d, expected none", cyc, kind);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (kind == 0) check("strobe_bit_index", idx, e.idx);
        end
    endtask

    function automatic bit exp_busy(input int c);
        return (c >= bs) && (c <= be);
    endfunction

    function automatic void trim_after(input int c);
        while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
    endfunction

    // Frame accepted in cycle c: optional half-bit wait, then B bits of P cycles, then one done cycle
    function automatic void push_frame(input int c, input int p, input int b);
        evt_t e;
        int   al;
        al = ALIGN_EN ? p / 2 : 0;
        for (int k = 0; k < b; k++) begin
            e.kind = 0; e.cyc = c + al + (k + 1) * p; e.idx = k;
            q.push_back(e);
        end
        e.kind = 1; e.cyc = c + al + b * p + 1; e.idx = 0;
        q.push_back(e);
        bs = c + 1;
        be = e.cyc;
    endfunction

    task automatic drive(input bit st, input bit ab, input bit r, input int p, input int b);
        evt_t e;
        @(posedge clk);
        #1;
        start = st; abort = ab; rst = r;
        clks_per_bit = CW'(p); bits_per_frame = IW'(b);
        cur_p = p; cur_b = b;
        if (ab && exp_busy(cyc)) begin
            trim_after(cyc);
            be = cyc;
        end
        if (st && !exp_busy(cyc)) begin
            if (p >= 2 && b >= 1) push_frame(cyc, p, b);
            else begin
                e.kind = 2; e.cyc = cyc + 1; e.idx = 0;
                q.push_back(e);
            end
        end
        if (r) begin
            trim_after(cyc);
            if (be > cyc) be = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, cur_p, cur_b);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            check("busy", busy, exp_busy(cyc));
            if (!busy) check("idle_bit_index", bit_index, 0);
            if (sample_strobe) expect_evt(0, bit_index);
            if (frame_done) expect_evt(1, 0);
            if (cfg_err) expect_evt(2, 0);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_strobe", sample_strobe, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_cfg_err", cfg_err, 0);
        check("reset_bit_index", bit_index, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Nominal frame P=4, B=3
        drive(1'b1, 1'b0, 1'b0, 4, 3);
        idle(20);

        // Rejected configurations
        drive(1'b1, 1'b0, 1'b0, 1, 3);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 3, 0);
        idle(3);

        // Abort ten cycles after start
        drive(1'b1, 1'b0, 1'b0, 4, 3);
        idle(9);
        drive(1'b0, 1'b1, 1'b0, 4, 3);
        idle(10);

        // Inputs changed and start re-asserted while busy
        drive(1'b1, 1'b0, 1'b0, 4, 3);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 7, 3);
        idle(5);
        drive(1'b1, 1'b0, 1'b0, 7, 3);
        idle(20);

        // Reset mid-frame, then a minimal frame
        drive(1'b1, 1'b0, 1'b0, 4, 3);
        idle(6);
        drive(1'b0, 1'b0, 1'b1, 4, 3);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 2, 1);
        idle(10);

        // Largest bit period the counter can hold
        drive(1'b1, 1'b0, 1'b0, 15, 2);
        idle(45);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 15), $urandom_range(0, 6));
        end
        idle(120);
        check("pending_events", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_timer_ctrl.md
RX_TIMER_CTRL -- requirements
Module: rx_timer_ctrl

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4: width of the cycle counter and of clks_per_bit.
REQ-002 SHALL have parameter NUM_IDX_BITS, default 4: width of bits_per_frame and bit_index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the frame in progress.
REQ-007 SHALL have port clks_per_bit  input  NUM_CNT_BITS  bit period P in clk cycles.
REQ-008 SHALL have port bits_per_frame  input  NUM_IDX_BITS  bits per frame B.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port sample_strobe  output  1  one-cycle pulse at the end of each bit period.
REQ-011 SHALL have port bit_index  output  NUM_IDX_BITS  0-based index of the bit being timed.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the last bit.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 SHALL implement FSM states IDLE, ALIGN, RUN and DONE.
REQ-015 SHALL latch P and B on an accepted start; input changes while busy have no effect.
REQ-016 SHALL accept start in IDLE only if P>=2 and B>=1; otherwise stay in IDLE and pulse cfg_err the next cycle.
REQ-017 SHALL transition on accepted start: IDLE->ALIGN, with the cycle count at 1 on the first cycle in the new state.
REQ-018 SHALL hold ALIGN for floor(P/2) cycles, then go to RUN with cycle count 1 and bit_index 0.
REQ-019 SHALL, in RUN, increment the cycle count each clk; sample_strobe = (state==RUN && count==P), decoded combinationally.
REQ-020 SHALL, on a strobe cycle, wrap the count to 1 and increment bit_index if bit_index<B-1, else go to DONE.
REQ-021 SHALL assert frame_done for the single DONE cycle, then return to IDLE; start in DONE is ignored.
REQ-022 SHALL, on abort in ALIGN/RUN/DONE, go to IDLE next cycle with no frame_done; outputs of the abort cycle itself are unaffected.
REQ-023 SHALL ignore start while busy and abort while in IDLE.
REQ-024 SHALL hold bit_index at 0 in IDLE and ALIGN.
REQ-025 SHALL hold the cycle counter at NUM_CNT_BITS bits; P = 2^NUM_CNT_BITS-1 works without overflow.

Reset
REQ-026 SHALL, with rst high at a clk edge, enter IDLE, clear counters and latched P/B, and drive busy, sample_strobe, frame_done and cfg_err to 0 and bit_index to 0.
REQ-027 SHALL let rst override start and abort in the same cycle, including mid-frame.

Configuration
REQ-028 SHALL use macro RX_TIMER_ALIGN_EN: defined -> ALIGN is used as in REQ-017/018; undefined -> ALIGN is omitted and an accepted start goes directly IDLE->RUN with count 1.

Verification
REQ-029 SHALL test with ALIGN_EN: P=4, B=3, start at cycle 0 -> busy=1 from cycle 1; sample_strobe at cycles 6, 10, 14 with bit_index 0, 1, 2; frame_done at 15; busy=0 at 16.
REQ-030 SHALL test without ALIGN_EN: P=4, B=3, start at cycle 0 -> strobes at cycles 4, 8, 12; frame_done at 13.
REQ-031 SHALL test config rejection: start with P=1, B=3 -> cfg_err=1 next cycle, busy stays 0; start with P=3, B=0 -> same result.
REQ-032 SHALL test abort: with ALIGN_EN, P=4, B=3, abort at cycle 10 (strobe cycle) -> strobe is seen at 10, busy=0 at 11, no frame_done.
REQ-033 SHALL test latching: change clks_per_bit 4->7 at cycle 2 -> strobe spacing stays 4; a start asserted at cycle 8 is ignored.
REQ-034 SHALL test reset mid-frame: rst at cycle 7 -> all outputs 0 at cycle 8; a new start at cycle 9 with P=2, B=1 (ALIGN_EN) -> strobe at cycle 12, frame_done at 13.
